// File: rtl/mega1_video_pkg.sv
// Shared constants and FSM state type for the scanline fetch arbiter.
//   NREQ    : default number of requesters (tilemap layers + sprite engine)
//   SPR_IDX : index of the sprite engine, always the highest requester
//   AW, DW  : default read address / data widths
package mega1_video_pkg;

  localparam int NREQ    = 4;
  localparam int SPR_IDX = NREQ - 1;
  localparam int AW      = 22;
  localparam int DW      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/scanline_fetch_arbiter_if.sv
// Fetch/memory bus bundle between the layer/sprite fetchers, the arbiter and
// the memory controller read port.
//   slave  : arbiter view (takes requests and memory responses, drives grants,
//            return data and the memory request)
//   master : surrounding system view (fetchers + memory controller)
interface scanline_fetch_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 22,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    rd_valid;
  logic [DW-1:0]      rd_data;
  logic               mem_req;
  logic [AW-1:0]      mem_addr;
  logic               mem_ack;
  logic               mem_valid;
  logic [DW-1:0]      mem_data;

  modport slave (
    input  req, req_addr, mem_ack, mem_valid, mem_data,
    output ack, rd_valid, rd_data, mem_req, mem_addr
  );

  modport master (
    output req, req_addr, mem_ack, mem_valid, mem_data,
    input  ack, rd_valid, rd_data, mem_req, mem_addr
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   i_elig   : eligible requester mask
//   i_last   : index granted last; search starts at the index after it
//   o_onehot : one-hot winner
//   o_idx    : winner index
//   o_any    : at least one requester eligible
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
    // last_grant itself is visited last so it only wins when alone
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(i_last) + k) % NREQ);
      if (!o_any && i_elig[w_cand]) begin
        o_any            = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scanline_fetch_arbiter.sv
// Shares the graphics ROM/SDRAM read port between the tilemap layer fetchers
// (indices 0..NREQ-2) and the sprite line engine (index NREQ-1). Tilemaps are
// favoured during active display, all requesters compete during hblank.
// Also generates per-line / per-frame start strobes from hbl/vbl falling edges.
//   clk, reset          : system clock, synchronous active-high reset
//   clk_en_pix          : pixel clock enable (gates strobe sampling only)
//   hc, vc              : raster counters from the timing generator
//   hbl, vbl            : horizontal / vertical blank
//   line_start          : pulse on the enabled cycle where hbl falls
//   frame_start         : pulse on the enabled cycle where vbl falls
//   bus                 : request/grant/return and memory read port bundle
module scanline_fetch_arbiter
  import mega1_video_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 22,
  parameter int DW   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en_pix,
  input  logic [8:0]               hc,
  input  logic [8:0]               vc,
  input  logic                     hbl,
  input  logic                     vbl,
  output logic                     line_start,
  output logic                     frame_start,
  scanline_fetch_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] TILE_MASK = ~(NREQ'(1) << (NREQ - 1));

  arb_state_t      r_state, w_state_nxt;
  logic [NREQ-1:0] r_owner_oh;
  logic [IW-1:0]   r_owner_idx;
  logic [IW-1:0]   r_last_grant;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_rd_data;
  logic [NREQ-1:0] r_rd_valid;
  logic            r_hbl_d, r_vbl_d, r_pix_seen;

  logic [NREQ-1:0] w_tile_req, w_elig, w_win_oh;
  logic [IW-1:0]   w_win_idx;
  logic            w_win_any, w_issue_done, w_data_done;

  // During active display the sprite engine only competes when no tilemap
  // layer is asking, so an otherwise idle port is never left unused.
  assign w_tile_req = bus.req & TILE_MASK;
  assign w_elig     = hbl ? bus.req : ((|w_tile_req) ? w_tile_req : bus.req);

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_elig   (w_elig),
    .i_last   (r_last_grant),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_any    (w_win_any)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_issue_done = 1'b0;
    w_data_done  = 1'b0;
    unique case (r_state)
      IDLE:    if (w_win_any) w_state_nxt = ISSUE;
      ISSUE:   if (bus.mem_ack) begin
                 w_state_nxt  = WAIT;
                 w_issue_done = 1'b1;
               end
      WAIT:    if (bus.mem_valid) begin
                 w_state_nxt = IDLE;
                 w_data_done = 1'b1;
               end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner_oh   <= '0;
      r_owner_idx  <= '0;
      r_last_grant <= IW'(NREQ - 1);
      r_mem_addr   <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= '0;
      if (r_state == IDLE && w_win_any) begin
        r_owner_oh  <= w_win_oh;
        r_owner_idx <= w_win_idx;
        r_mem_addr  <= bus.req_addr[int'(w_win_idx) * AW +: AW];
      end
      if (w_issue_done) r_last_grant <= r_owner_idx;
      if (w_data_done) begin
        r_rd_data  <= bus.mem_data;
        r_rd_valid <= r_owner_oh;
      end
    end
  end

  assign bus.mem_req  = (r_state == ISSUE) && !reset;
  assign bus.mem_addr = r_mem_addr;
  assign bus.ack      = (w_issue_done && !reset) ? r_owner_oh : '0;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;

  // r_pix_seen suppresses a strobe on the first enabled pixel after reset,
  // whatever level hbl/vbl happen to be at.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hbl_d    <= 1'b1;
      r_vbl_d    <= 1'b1;
      r_pix_seen <= 1'b0;
    end else if (clk_en_pix) begin
      r_hbl_d    <= hbl;
      r_vbl_d    <= vbl;
      r_pix_seen <= 1'b1;
    end
  end

  assign line_start  = !reset && clk_en_pix && r_pix_seen && r_hbl_d && !hbl;
  assign frame_start = !reset && clk_en_pix && r_pix_seen && r_vbl_d && !vbl;

endmodule

// File: tb/tb_scanline_fetch_arbiter.sv
module tb_scanline_fetch_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en_pix;
  logic [8:0] hc, vc;
  logic       hbl, vbl;
  logic       line_start, frame_start;
  int         total = 0;
  int         bad   = 0;

  scanline_fetch_arbiter_if #(.NREQ(4), .AW(22), .DW(32)) bus ();

  scanline_fetch_arbiter #(.NREQ(4), .AW(22), .DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en_pix  (clk_en_pix),
    .hc          (hc),
    .vc          (vc),
    .hbl         (hbl),
    .vbl         (vbl),
    .line_start  (line_start),
    .frame_start (frame_start),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset         = 1'b1;
    bus.req       = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives one transaction with immediate mem_ack / mem_valid; returns the
  // index that received ack, or -1 if mem_req never came or no ack appeared.
  task automatic run_txn(input logic [31:0] data, output int g);
    int n;
    g = -1;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (bus.mem_req === 1'b1) begin
      bus.mem_ack = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) if (bus.ack[i] === 1'b1) g = i;
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_valid = 1'b1;
      bus.mem_data  = data;
      tick();
      bus.mem_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    hbl = 1'b1;
    vbl = 1'b1;
    clk_en_pix = 1'b0;
    reset_dut();
    #1;
    total++;
    if (bus.mem_req !== 1'b0 || bus.ack !== 4'b0 || bus.rd_valid !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl: mem_req=%b ack=%b rd_valid=%b want 0/0000/0000",
               bus.mem_req, bus.ack, bus.rd_valid);
    end
    total++;
    if (bus.rd_data !== 32'h0 || bus.mem_addr !== 22'h0) begin
      bad++;
      $display("FAIL reset_data: rd_data=%h mem_addr=%h want 0/0", bus.rd_data, bus.mem_addr);
    end
    total++;
    if (line_start !== 1'b0 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobe: line=%b frame=%b want 0/0", line_start, frame_start);
    end
  endtask

  task automatic test_single();
    hbl = 1'b0;
    reset_dut();
    bus.req = 4'b0001;
    tick();
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 22'h001234) begin
      bad++;
      $display("FAIL single_issue: mem_req=%b mem_addr=%h want 1/001234", bus.mem_req, bus.mem_addr);
    end
    total++;
    if (bus.ack !== 4'b0000) begin
      bad++;
      $display("FAIL single_noack: ack=%b want 0000", bus.ack);
    end
    tick();
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 22'h001234) begin
      bad++;
      $display("FAIL single_hold: mem_req=%b mem_addr=%h want 1/001234", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack = 1'b1;
    #1;
    total++;
    if (bus.ack !== 4'b0001) begin
      bad++;
      $display("FAIL single_ack: ack=%b want 0001", bus.ack);
    end
    tick();
    bus.mem_ack = 1'b0;
    bus.req     = 4'b0000;
    total++;
    if (bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL single_drop: mem_req=%b want 0", bus.mem_req);
    end
    bus.mem_valid = 1'b1;
    bus.mem_data  = 32'hDEADBEEF;
    #1;
    total++;
    if (bus.rd_valid !== 4'b0000) begin
      bad++;
      $display("FAIL single_early: rd_valid=%b want 0000", bus.rd_valid);
    end
    tick();
    bus.mem_valid = 1'b0;
    total++;
    if (bus.rd_valid !== 4'b0001 || bus.rd_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_data: rd_valid=%b rd_data=%h want 0001/deadbeef", bus.rd_valid, bus.rd_data);
    end
    bus.mem_valid = 1'b1;
    bus.mem_data  = 32'h11111111;
    tick();
    bus.mem_valid = 1'b0;
    total++;
    if (bus.rd_valid !== 4'b0000 || bus.rd_data !== 32'hDEADBEEF || bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL single_spurious: rd_valid=%b rd_data=%h mem_req=%b want 0000/deadbeef/0",
               bus.rd_valid, bus.rd_data, bus.mem_req);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int exp_g [6] = '{0, 1, 2, 0, 1, 2};
    hbl = 1'b0;
    reset_dut();
    bus.req = 4'b0111;
    foreach (exp_g[k]) begin
      run_txn(32'h100 + k, g);
      total++;
      if (g !== exp_g[k]) begin
        bad++;
        $display("FAIL rr_grant[%0d]: got %0d want %0d", k, g, exp_g[k]);
      end
    end
  endtask

  task automatic test_hblank_class();
    int g;
    int exp_g [5] = '{0, 0, 3, 0, 3};
    hbl = 1'b0;
    reset_dut();
    bus.req = 4'b1001;
    foreach (exp_g[k]) begin
      if (k == 2) hbl = 1'b1;
      run_txn(32'h200 + k, g);
      total++;
      if (g !== exp_g[k]) begin
        bad++;
        $display("FAIL hbl_grant[%0d]: got %0d want %0d", k, g, exp_g[k]);
      end
    end
    hbl = 1'b0;
  endtask

  task automatic test_sprite_alone();
    int g;
    hbl = 1'b0;
    reset_dut();
    bus.req = 4'b1000;
    run_txn(32'h300, g);
    total++;
    if (g !== 3) begin
      bad++;
      $display("FAIL sprite_alone: got %0d want 3", g);
    end
    total++;
    if (bus.rd_valid !== 4'b1000 || bus.rd_data !== 32'h300) begin
      bad++;
      $display("FAIL sprite_data: rd_valid=%b rd_data=%h want 1000/00000300", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_reset_in_wait();
    int g;
    hbl = 1'b0;
    reset_dut();
    bus.req = 4'b0100;
    tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.req     = 4'b0000;
    reset       = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_data  = 32'hCAFEF00D;
    tick();
    bus.mem_valid = 1'b0;
    total++;
    if (bus.rd_valid !== 4'b0000 || bus.rd_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_wait_data: rd_valid=%b rd_data=%h want 0000/0", bus.rd_valid, bus.rd_data);
    end
    total++;
    if (bus.mem_req !== 1'b0 || bus.ack !== 4'b0000 || bus.mem_addr !== 22'h0) begin
      bad++;
      $display("FAIL rst_wait_ctrl: mem_req=%b ack=%b mem_addr=%h want 0/0000/0",
               bus.mem_req, bus.ack, bus.mem_addr);
    end
    bus.req = 4'b0110;
    run_txn(32'h400, g);
    total++;
    if (g !== 1) begin
      bad++;
      $display("FAIL rst_wait_first: got %0d want 1", g);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_strobes();
    hbl = 1'b0;
    vbl = 1'b0;
    clk_en_pix = 1'b0;
    reset_dut();
    clk_en_pix = 1'b1;
    #1;
    total++;
    if (line_start !== 1'b0 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL strobe_first_pix: line=%b frame=%b want 0/0", line_start, frame_start);
    end
    tick();
    hbl = 1'b1;
    tick();
    hbl = 1'b0;
    #1;
    total++;
    if (line_start !== 1'b1 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL strobe_line: line=%b frame=%b want 1/0", line_start, frame_start);
    end
    tick();
    total++;
    if (line_start !== 1'b0) begin
      bad++;
      $display("FAIL strobe_line_width: line=%b want 0", line_start);
    end
    hbl = 1'b1;
    tick();
    hbl        = 1'b0;
    clk_en_pix = 1'b0;
    #1;
    total++;
    if (line_start !== 1'b0) begin
      bad++;
      $display("FAIL strobe_gated: line=%b want 0", line_start);
    end
    tick();
    clk_en_pix = 1'b1;
    #1;
    total++;
    if (line_start !== 1'b1) begin
      bad++;
      $display("FAIL strobe_enabled: line=%b want 1", line_start);
    end
    tick();
    hbl = 1'b1;
    vbl = 1'b1;
    tick();
    hbl = 1'b0;
    vbl = 1'b0;
    #1;
    total++;
    if (line_start !== 1'b1 || frame_start !== 1'b1) begin
      bad++;
      $display("FAIL strobe_both: line=%b frame=%b want 1/1", line_start, frame_start);
    end
    tick();
    total++;
    if (line_start !== 1'b0 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL strobe_both_width: line=%b frame=%b want 0/0", line_start, frame_start);
    end
  endtask

  initial begin
    reset         = 1'b1;
    clk_en_pix    = 1'b0;
    hc            = 9'd0;
    vc            = 9'd0;
    hbl           = 1'b1;
    vbl           = 1'b1;
    bus.req       = '0;
    bus.req_addr  = {22'h3F0003, 22'h2A0002, 22'h100001, 22'h001234};
    bus.mem_ack   = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;

    test_reset();
    test_single();
    test_round_robin();
    test_hblank_class();
    test_sprite_alone();
    test_reset_in_wait();
    test_strobes();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
